// File: rtl/clk_rst_seq_gen.sv
// Slow-clock / reset generator: per-channel programmable clock dividers plus a
// lock-gated peripheral reset sequencer with synchronised inputs and hold-off.
module clk_rst_seq_gen #(
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned DIV_W        = 16,
   parameter int unsigned DIV_INIT     = 256,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned RST_HOLD_CYC = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pll_locked,
   input  logic                    ext_rst_n,
   input  logic [NUM_CH*DIV_W-1:0] div_val,
   input  logic [NUM_CH-1:0]       div_load,
   input  logic [NUM_CH-1:0]       ch_en,
   output logic [NUM_CH-1:0]       clk_div_out,
   output logic [NUM_CH-1:0]       clk_div_tick,
   output logic                    periph_rst_n,
   output logic                    periph_rst,
   output logic [1:0]              seq_state
);

   localparam int unsigned HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;

   localparam logic [1:0] ST_RST_ASSERT = 2'd0;
   localparam logic [1:0] ST_WAIT_LOCK  = 2'd1;
   localparam logic [1:0] ST_HOLD       = 2'd2;
   localparam logic [1:0] ST_RUN        = 2'd3;

   logic [SYNC_STAGES-1:0] r_lk_sync;
   logic [SYNC_STAGES-1:0] r_er_sync;
   logic                   w_lk_s;
   logic                   w_er_s;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic              r_periph_rst_n;
   logic              r_periph_rst;

   // Input synchronisers for the asynchronous lock and board reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lk_sync <= '0;
         r_er_sync <= '0;
      end else begin
         r_lk_sync <= {r_lk_sync[SYNC_STAGES-2:0], pll_locked};
         r_er_sync <= {r_er_sync[SYNC_STAGES-2:0], ext_rst_n};
      end
   end

   assign w_lk_s = r_lk_sync[SYNC_STAGES-1];
   assign w_er_s = r_er_sync[SYNC_STAGES-1];

   // Sequencer state register; reset outputs follow the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_RST_ASSERT;
         r_hold_cnt     <= '0;
         r_periph_rst_n <= 1'b0;
         r_periph_rst   <= 1'b1;
      end else begin
         r_state        <= w_state_nxt;
         r_hold_cnt     <= w_hold_nxt;
         r_periph_rst_n <= (w_state_nxt == ST_RUN);
         r_periph_rst   <= (w_state_nxt != ST_RUN);
      end
   end

   // Sequencer next-state; a low board reset overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      if (!w_er_s) begin
         w_state_nxt = ST_RST_ASSERT;
         w_hold_nxt  = '0;
      end else begin
         case (r_state)
            ST_RST_ASSERT: w_state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
               if (w_lk_s) begin
                  w_state_nxt = ST_HOLD;
                  w_hold_nxt  = '0;
               end
            end
            ST_HOLD: begin
               if (!w_lk_s) begin
                  w_state_nxt = ST_WAIT_LOCK;
               end else if (r_hold_cnt == HOLD_W'(RST_HOLD_CYC - 1)) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_hold_nxt = r_hold_cnt + HOLD_W'(1);
               end
            end
            ST_RUN: begin
               if (!w_lk_s) w_state_nxt = ST_WAIT_LOCK;
            end
            default: w_state_nxt = ST_RST_ASSERT;
         endcase
      end
   end

   assign periph_rst_n = r_periph_rst_n;
   assign periph_rst   = r_periph_rst;
   assign seq_state    = r_state;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [DIV_W-1:0] r_cnt;
      logic [DIV_W-1:0] r_act;
      logic [DIV_W-1:0] r_shd;
      logic             r_run;
      logic             r_out;
      logic             r_tick;
      logic [DIV_W-1:0] w_val;
      logic [DIV_W-1:0] w_n;
      logic [DIV_W-1:0] w_n_nxt;
      logic [DIV_W-1:0] w_cnt_nxt;
      logic [DIV_W-1:0] w_act_nxt;
      logic [DIV_W-1:0] w_shd_nxt;
      logic             w_run_nxt;
      logic             w_wrap;

      assign w_val   = div_val[g*DIV_W +: DIV_W];
      assign w_n     = (r_act < DIV_W'(2)) ? DIV_W'(2) : r_act;
      assign w_n_nxt = (w_act_nxt < DIV_W'(2)) ? DIV_W'(2) : w_act_nxt;
      assign w_wrap  = (r_cnt == w_n - DIV_W'(1));

      // Divisor changes and disables only land on the wrap, so periods never truncate
      always_comb begin
         w_cnt_nxt = r_cnt;
         w_act_nxt = r_act;
         w_shd_nxt = r_shd;
         w_run_nxt = r_run;
         if (r_run) begin
            if (div_load[g]) w_shd_nxt = w_val;
            if (w_wrap) begin
               w_cnt_nxt = '0;
               w_act_nxt = r_shd;
               w_run_nxt = ch_en[g];
            end else begin
               w_cnt_nxt = r_cnt + DIV_W'(1);
            end
         end else begin
            w_cnt_nxt = '0;
            if (div_load[g]) begin
               w_act_nxt = w_val;
               w_shd_nxt = w_val;
            end
            w_run_nxt = ch_en[g];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt  <= '0;
            r_act  <= DIV_W'(DIV_INIT);
            r_shd  <= DIV_W'(DIV_INIT);
            r_run  <= 1'b0;
            r_out  <= 1'b0;
            r_tick <= 1'b0;
         end else begin
            r_cnt  <= w_cnt_nxt;
            r_act  <= w_act_nxt;
            r_shd  <= w_shd_nxt;
            r_run  <= w_run_nxt;
            r_out  <= w_run_nxt && (w_cnt_nxt < (w_n_nxt >> 1));
            r_tick <= w_run_nxt && (w_cnt_nxt == '0);
         end
      end

      assign clk_div_out[g]  = r_out;
      assign clk_div_tick[g] = r_tick;
   end

endmodule
